// File: rtl/store_monitor.sv
// store_monitor: watches CPU data-memory stores, decides pass/fail of a test
// program from a store to a magic address, enforces a cycle budget, and logs
// every observed store (address, data, pc) into a small show-ahead FIFO.
module store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter int unsigned TIMEOUT_CYCLES = 20,
    parameter int unsigned DEPTH          = 8,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          memwrite,
    input  logic [31:0]   dataaddr,
    input  logic [31:0]   writedata,
    input  logic [31:0]   pc,
    input  logic          log_rd,
    output logic          log_valid,
    output logic [31:0]   log_addr,
    output logic [31:0]   log_data,
    output logic [31:0]   log_pc,
    output logic [AW:0]   log_count,
    output logic          overflow,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [15:0]   cycle_count,
    output logic [15:0]   store_count
);

    // Last RUN cycle index that is still inside the budget; reaching it
    // without a terminating store ends the test as a failure.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FULL_COUNT   = (AW + 1)'(DEPTH);
    localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Store observation
    // ------------------------------------------------------------------
    logic in_run;
    logic store_seen;
    logic end_store;
    logic end_data_ok;
    logic budget_spent;

    assign in_run       = (state == ST_RUN);
    assign store_seen   = in_run && memwrite;
    assign end_store    = store_seen && (dataaddr == PASS_ADDR);
    assign end_data_ok  = (writedata == PASS_DATA);
    assign budget_spent = (cycle_count == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // Test-status FSM
    // ------------------------------------------------------------------

    // State register; asynchronous reset returns to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a terminating store outranks the timeout.
    // NOTE: state_next gets a default before the case so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_store) begin
                    state_next = end_data_ok ? ST_PASS : ST_FAIL;
                end else if (budget_spent) begin
                    state_next = ST_FAIL;
                end
            end
            ST_PASS: state_next = ST_PASS;
            ST_FAIL: state_next = ST_FAIL;
            default: state_next = ST_IDLE;
        endcase
    end

    assign done = (state == ST_PASS) || (state == ST_FAIL);
    assign pass = (state == ST_PASS);
    assign fail = (state == ST_FAIL);

    // ------------------------------------------------------------------
    // Activity counters (only advance while RUN, saturating)
    // ------------------------------------------------------------------

    // RUN-cycle and RUN-store counters; frozen in every other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            store_count <= '0;
        end else if (in_run) begin
            if (cycle_count != COUNT_MAX) begin
                cycle_count <= cycle_count + 16'd1;
            end
            if (memwrite && (store_count != COUNT_MAX)) begin
                store_count <= store_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store-log FIFO
    // ------------------------------------------------------------------
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            pop;
    logic            push_accept;
    logic            push_drop;
    entry_t          head;

    assign log_valid   = (log_count != '0);
    assign full        = (log_count == FULL_COUNT);
    assign pop         = log_rd && log_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_accept = store_seen && (!full || pop);
    assign push_drop   = store_seen && full && !pop;

    // Entry storage, written at the tail on each accepted push.
    // NOTE: the storage array carries no reset; log_valid/log_count gate
    // every read, so stale contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= '{addr: dataaddr, data: writedata, pc: pc};
        end
    end

    // Pointers, occupancy and sticky overflow; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_accept, pop})
                2'b10:   log_count <= log_count + 1'b1;
                2'b01:   log_count <= log_count - 1'b1;
                default: log_count <= log_count;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Show-ahead head entry straight from storage.
    assign head     = mem[rd_ptr];
    assign log_addr = head.addr;
    assign log_data = head.data;
    assign log_pc   = head.pc;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor with default parameters
// (PASS_ADDR=84, PASS_DATA=7, TIMEOUT_CYCLES=20, DEPTH=8).
module tb_store_monitor;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] pc;
    logic        log_rd;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [31:0] log_pc;
    logic [3:0]  log_count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] cycle_count;
    logic [15:0] store_count;

    int checks = 0;
    int errors = 0;

    store_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .memwrite    (memwrite),
        .dataaddr    (dataaddr),
        .writedata   (writedata),
        .pc          (pc),
        .log_rd      (log_rd),
        .log_valid   (log_valid),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .log_pc      (log_pc),
        .log_count   (log_count),
        .overflow    (overflow),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .cycle_count (cycle_count),
        .store_count (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are then observed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        enable = 1'b0;
        memwrite = 1'b0;
        log_rd = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        memwrite  = 1'b1;
        dataaddr  = a;
        writedata = d;
        pc        = p;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic pop_one();
        log_rd = 1'b1;
        step();
        log_rd = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({done, pass, fail} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 000", {done, pass, fail});
        end
        checks++;
        if ({log_valid, overflow, log_count} !== 6'd0) begin
            errors++;
            $display("FAIL reset_fifo: got valid=%b ovf=%b count=%0d expected 0/0/0", log_valid, overflow, log_count);
        end
        checks++;
        if ({cycle_count, store_count} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got cyc=%0d st=%0d expected 0/0", cycle_count, store_count);
        end
        // enable low: stays IDLE, counters frozen
        step();
        step();
        checks++;
        if (cycle_count !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got cyc=%0d done=%b expected 0/0", cycle_count, done);
        end
    endtask

    task automatic test_pass();
        apply_reset();
        start_run();
        store(32'd80, 32'h11, 32'h40);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL pass_early_done: got %b expected 0", done);
        end
        store(32'd84, 32'd7, 32'h44);
        checks++;
        if ({done, pass, fail} !== 3'b110) begin
            errors++;
            $display("FAIL pass_status: got %b expected 110", {done, pass, fail});
        end
        checks++;
        if (store_count !== 16'd2 || cycle_count !== 16'd2) begin
            errors++;
            $display("FAIL pass_counts: got st=%0d cyc=%0d expected 2/2", store_count, cycle_count);
        end
        checks++;
        if (log_count !== 4'd2 || log_valid !== 1'b1) begin
            errors++;
            $display("FAIL pass_log_count: got %0d valid=%b expected 2/1", log_count, log_valid);
        end
        checks++;
        if ({log_addr, log_data, log_pc} !== {32'd80, 32'h11, 32'h40}) begin
            errors++;
            $display("FAIL pass_head1: got %0h/%0h/%0h expected 50/11/40", log_addr, log_data, log_pc);
        end
        pop_one();
        checks++;
        if ({log_addr, log_data, log_pc} !== {32'd84, 32'd7, 32'h44} || log_count !== 4'd1) begin
            errors++;
            $display("FAIL pass_head2: got %0h/%0h/%0h count=%0d expected 54/7/44 count=1", log_addr, log_data, log_pc, log_count);
        end
        pop_one();
        checks++;
        if (log_valid !== 1'b0 || log_count !== 4'd0) begin
            errors++;
            $display("FAIL pass_drain: got valid=%b count=%0d expected 0/0", log_valid, log_count);
        end
        // pop while empty is ignored
        pop_one();
        checks++;
        if (log_count !== 4'd0 || log_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty: got count=%0d valid=%b expected 0/0", log_count, log_valid);
        end
    endtask

    task automatic test_fail();
        apply_reset();
        start_run();
        store(32'd84, 32'd5, 32'h10);
        checks++;
        if ({done, pass, fail} !== 3'b101) begin
            errors++;
            $display("FAIL fail_status: got %b expected 101", {done, pass, fail});
        end
        checks++;
        if (log_count !== 4'd1 || store_count !== 16'd1) begin
            errors++;
            $display("FAIL fail_log: got count=%0d st=%0d expected 1/1", log_count, store_count);
        end
        store(32'd80, 32'd1, 32'h14);
        enable = 1'b1;
        store(32'd84, 32'd7, 32'h18);
        enable = 1'b0;
        checks++;
        if (log_count !== 4'd1 || store_count !== 16'd1 || cycle_count !== 16'd1) begin
            errors++;
            $display("FAIL fail_frozen: got count=%0d st=%0d cyc=%0d expected 1/1/1", log_count, store_count, cycle_count);
        end
        checks++;
        if ({done, pass, fail} !== 3'b101) begin
            errors++;
            $display("FAIL fail_terminal: got %b expected 101", {done, pass, fail});
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        start_run();
        for (int i = 0; i < 19; i++) step();
        checks++;
        if (fail !== 1'b0 || cycle_count !== 16'd19) begin
            errors++;
            $display("FAIL timeout_early: got fail=%b cyc=%0d expected 0/19", fail, cycle_count);
        end
        step();
        checks++;
        if ({done, pass, fail} !== 3'b101 || cycle_count !== 16'd20) begin
            errors++;
            $display("FAIL timeout_fail: got %b cyc=%0d expected 101/20", {done, pass, fail}, cycle_count);
        end
        step();
        checks++;
        if (cycle_count !== 16'd20) begin
            errors++;
            $display("FAIL timeout_frozen: got cyc=%0d expected 20", cycle_count);
        end
        // Terminating store on the 20th cycle wins over the timeout
        apply_reset();
        start_run();
        for (int i = 0; i < 19; i++) step();
        store(32'd84, 32'd7, 32'h80);
        checks++;
        if ({done, pass, fail} !== 3'b110 || cycle_count !== 16'd20) begin
            errors++;
            $display("FAIL timeout_pass_priority: got %b cyc=%0d expected 110/20", {done, pass, fail}, cycle_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        start_run();
        for (int i = 0; i < 9; i++) store(32'h100 + 32'(i), 32'(i), 32'h200 + 32'(4 * i));
        checks++;
        if (log_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: got count=%0d ovf=%b expected 8/1", log_count, overflow);
        end
        checks++;
        if ({log_addr, log_data, log_pc} !== {32'h100, 32'd0, 32'h200}) begin
            errors++;
            $display("FAIL ovf_head: got %0h/%0h/%0h expected 100/0/200", log_addr, log_data, log_pc);
        end
        pop_one();
        checks++;
        if (log_addr !== 32'h101 || log_count !== 4'd7 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pop: got addr=%0h count=%0d ovf=%b expected 101/7/1", log_addr, log_count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start_run();
        for (int i = 0; i < 8; i++) store(32'h100 + 32'(i), 32'(i), 32'h200 + 32'(4 * i));
        checks++;
        if (log_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got count=%0d ovf=%b expected 8/0", log_count, overflow);
        end
        log_rd = 1'b1;
        store(32'h108, 32'd8, 32'h220);
        log_rd = 1'b0;
        checks++;
        if (log_count !== 4'd8 || overflow !== 1'b0 || log_addr !== 32'h101) begin
            errors++;
            $display("FAIL b2b_push_pop: got count=%0d ovf=%b addr=%0h expected 8/0/101", log_count, overflow, log_addr);
        end
        for (int i = 0; i < 7; i++) pop_one();
        checks++;
        if ({log_addr, log_data, log_pc} !== {32'h108, 32'd8, 32'h220} || log_count !== 4'd1) begin
            errors++;
            $display("FAIL b2b_wrap_tail: got %0h/%0h/%0h count=%0d expected 108/8/220 count=1", log_addr, log_data, log_pc, log_count);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start_run();
        store(32'h10, 32'd1, 32'h0);
        store(32'h14, 32'd2, 32'h4);
        store(32'h18, 32'd3, 32'h8);
        checks++;
        if (log_count !== 4'd3) begin
            errors++;
            $display("FAIL arst_pre_count: got %0d expected 3", log_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (log_valid !== 1'b0 || log_count !== 4'd0 || done !== 1'b0 || cycle_count !== 16'd0 || store_count !== 16'd0) begin
            errors++;
            $display("FAIL arst_immediate: got valid=%b count=%0d done=%b cyc=%0d st=%0d expected all 0", log_valid, log_count, done, cycle_count, store_count);
        end
        reset = 1'b0;
        store(32'd80, 32'd1, 32'h0);
        store(32'd84, 32'd7, 32'h4);
        checks++;
        if (store_count !== 16'd0 || log_count !== 4'd0 || cycle_count !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle_ignores: got st=%0d count=%0d cyc=%0d done=%b expected 0/0/0/0", store_count, log_count, cycle_count, done);
        end
        start_run();
        store(32'd80, 32'd9, 32'h8);
        checks++;
        if (store_count !== 16'd1 || log_count !== 4'd1 || log_data !== 32'd9) begin
            errors++;
            $display("FAIL arst_resume: got st=%0d count=%0d data=%0h expected 1/1/9", store_count, log_count, log_data);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        memwrite  = 1'b0;
        dataaddr  = '0;
        writedata = '0;
        pc        = '0;
        log_rd    = 1'b0;
        #3;
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADDR, default 32'd84, store address that ends the test.
REQ-002 Parameter PASS_DATA, default 32'd7, data value at PASS_ADDR meaning success.
REQ-003 Parameter TIMEOUT_CYCLES, default 20, RUN-state cycle budget before forced fail.
REQ-004 Parameter DEPTH, default 8 (power of two), store-log FIFO entries; AW = log2(DEPTH).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  leaves IDLE and starts monitoring.
REQ-008 memwrite  input  1  CPU data-memory write strobe.
REQ-009 dataaddr  input  32  CPU data-memory address.
REQ-010 writedata  input  32  CPU store data.
REQ-011 pc  input  32  CPU program counter, logged with each store.
REQ-012 log_rd  input  1  pop request for log FIFO head.
REQ-013 log_valid  output  1  FIFO non-empty.
REQ-014 log_addr / log_data / log_pc  output  32 each  head entry, show-ahead.
REQ-015 log_count  output  AW+1  entries held.
REQ-016 overflow  output  1  sticky: a store was dropped.
REQ-017 done / pass / fail  output  1 each  test status.
REQ-018 cycle_count / store_count  output  16 each  RUN cycles and RUN stores observed.

Function
REQ-019 FSM states IDLE, RUN, PASS, FAIL; PASS and FAIL terminal until reset.
REQ-020 IDLE -> RUN on clk edge with enable=1; enable ignored in other states.
REQ-021 In RUN, memwrite=1 with dataaddr==PASS_ADDR and writedata==PASS_DATA -> PASS next edge.
REQ-022 In RUN, memwrite=1 with dataaddr==PASS_ADDR and writedata!=PASS_DATA -> FAIL next edge.
REQ-023 In RUN, cycle_count==TIMEOUT_CYCLES-1 with no PASS_ADDR store that cycle -> FAIL; a PASS_ADDR store in that same cycle takes priority per REQ-021/022.
REQ-024 cycle_count increments once per RUN cycle, saturates at 16'hFFFF, frozen outside RUN.
REQ-025 store_count increments per RUN cycle with memwrite=1, saturates at 16'hFFFF.
REQ-026 Push {dataaddr, writedata, pc} into FIFO each RUN cycle with memwrite=1, including the terminating store; no pushes in IDLE/PASS/FAIL.
REQ-027 Pop when log_rd=1 and log_valid=1; log_rd while empty ignored.
REQ-028 Push and pop same cycle: both occur, log_count unchanged, valid even when full.
REQ-029 Push while full without pop: entry dropped, overflow set, held until reset.
REQ-030 Read/write pointers wrap modulo DEPTH; log_count = entries, 0..DEPTH.
REQ-031 log_addr/log_data/log_pc reflect head entry combinationally from storage; undefined contents when log_valid=0 are don't-care.
REQ-032 done = (state PASS or FAIL); pass = state PASS; fail = state FAIL; all registered-state decodes, no combinational path from inputs.

Reset
REQ-033 reset=1 asynchronously forces IDLE, pointers/log_count 0, log_valid 0, overflow 0, done/pass/fail 0, cycle_count 0, store_count 0.
REQ-034 Reset asserted mid-RUN or in PASS/FAIL discards FIFO contents and status; monitoring resumes only after reset=0 and enable=1.
REQ-035 FIFO storage array need not be reset.

Verification
REQ-036 Reset, enable, stores (80,0x11,pc=0x40),(84,7,pc=0x44) -> PASS next edge, done=1 pass=1, store_count=2, log pops give 80/0x11/0x40 then 84/7/0x44.
REQ-037 Enable, store (84,5) -> fail=1 next edge, pass=0, log_count=1; later stores not logged, store_count stays 1.
REQ-038 Enable, no stores for 20 cycles -> fail=1 after 20th RUN cycle, cycle_count=20; variant with (84,7) on 20th cycle -> pass=1.
REQ-039 DEPTH=8, 9 consecutive non-terminating stores, no pops -> log_count=8, overflow=1, first pop returns store #1; 9th store in same cycle as pop -> accepted, overflow stays 0.
REQ-040 Reset pulse asserted between clock edges mid-RUN with log_count=3 -> immediately log_valid=0, log_count=0, done=0, state IDLE; stores before enable not counted.
